// File: rtl/ice_hb_pkg.sv
// Shared definitions for the ICE host bus master.
// Holds the FSM state encoding, the bus width and the slave register address map.
package ice_hb_pkg;

    localparam int unsigned BusW = 32;

    // Slave register address map
    localparam logic [BusW-1:0] ICE_MASK_ADDR  = 32'h0880_4000;
    localparam logic [BusW-1:0] ICE_BRK_ADDR   = 32'h0880_4010;
    localparam logic [BusW-1:0] ICE_TRACE_ADDR = 32'h0880_4020;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StRdWait,
        StResp
    } state_e;

    // Word-aligned byte address check
    function automatic logic addr_aligned(input logic [BusW-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ice_hostbus_master_if.sv
// Command/response channel and ICE host bus signals as seen by the master.
// master modport: the initiator (ice_hostbus_master).
// slave modport : the debug controller plus the bus slaves, i.e. everything around it.
interface ice_hostbus_master_if;
    import ice_hb_pkg::*;

    logic            CMD_VALID;
    logic            CMD_READY;
    logic            CMD_WR;
    logic [BusW-1:0] CMD_ADDR;
    logic [BusW-1:0] CMD_WDATA;
    logic            RSP_VALID;
    logic            RSP_READY;
    logic [BusW-1:0] RSP_RDATA;
    logic            RSP_ERR;
    logic [BusW-1:0] ICEIFA;
    logic [BusW-1:0] ICEDI;
    logic [BusW-1:0] ICEDO;
    logic            ICEWR;
    logic            BUSY;

    modport master (
        input  CMD_VALID, CMD_WR, CMD_ADDR, CMD_WDATA, RSP_READY, ICEDO,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, ICEIFA, ICEDI, ICEWR, BUSY
    );

    modport slave (
        output CMD_VALID, CMD_WR, CMD_ADDR, CMD_WDATA, RSP_READY, ICEDO,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, ICEIFA, ICEDI, ICEWR, BUSY
    );

endinterface

// File: rtl/ice_hb_timer.sv
// Loadable down-counter that times each bus phase.
// Ports: clk_i/rst_i (sync active-high), load_i + load_val_i load a new count,
// zero_o is high while the count is 0. The count holds at 0 until reloaded.
module ice_hb_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ice_hostbus_master.sv
// ICE host bus initiator: runs one read or write bus cycle per accepted command
// and returns the result on the response channel. All outputs are registered.
// Ports: CLK, RST (sync active-high), hb (master modport: CMD_*, RSP_*, ICEIFA,
// ICEDI, ICEDO, ICEWR, BUSY).
module ice_hostbus_master
    import ice_hb_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    ice_hostbus_master_if.master  hb
);

    // The timer is loaded with N-1 on entry, so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SetupLd  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] StrobeLd = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HoldLd   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RdLd     = CNT_W'(RD_WAIT - 1);

    state_e          state_d, state_q;
    logic            is_wr_d, is_wr_q;
    logic            cmd_ready_d, cmd_ready_q;
    logic            rsp_valid_d, rsp_valid_q;
    logic [BusW-1:0] rsp_rdata_d, rsp_rdata_q;
    logic            rsp_err_d, rsp_err_q;
    logic [BusW-1:0] iceifa_d, iceifa_q;
    logic [BusW-1:0] icedi_d, icedi_q;
    logic            icewr_d, icewr_q;
    logic            busy_d, busy_q;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             accept;

    ice_hb_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // cmd_ready_q is only ever high in IDLE, so it alone gates acceptance.
    assign accept = cmd_ready_q & hb.CMD_VALID;

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        iceifa_d    = iceifa_q;
        icedi_d     = icedi_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!addr_aligned(hb.CMD_ADDR)) begin
                        // Bus stays idle; report the error straight away.
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d  = StSetup;
                        is_wr_d  = hb.CMD_WR;
                        iceifa_d = hb.CMD_ADDR;
                        icedi_d  = hb.CMD_WR ? hb.CMD_WDATA : '0;
                        tmr_load = 1'b1;
                        tmr_val  = SetupLd;
                    end
                end
            end
            StSetup: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (is_wr_q) begin
                        state_d = StStrobe;
                        tmr_val = StrobeLd;
                    end else begin
                        state_d = StRdWait;
                        tmr_val = RdLd;
                    end
                end
            end
            StStrobe: begin
                if (tmr_zero) begin
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = HoldLd;
                end
            end
            StHold: begin
                if (tmr_zero) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            StRdWait: begin
                if (tmr_zero) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = hb.ICEDO;
                end
            end
            StResp: begin
                if (hb.RSP_READY) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    iceifa_d    = '0;
                    icedi_d     = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        icewr_d = (state_d == StStrobe);
        busy_d  = (state_d != StIdle);
        // Ready comes one cycle after re-entering IDLE, never alongside a response.
        cmd_ready_d = (state_q == StIdle) && !accept;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            is_wr_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            iceifa_q    <= '0;
            icedi_q     <= '0;
            icewr_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            iceifa_q    <= iceifa_d;
            icedi_q     <= icedi_d;
            icewr_q     <= icewr_d;
            busy_q      <= busy_d;
        end
    end

    assign hb.CMD_READY = cmd_ready_q;
    assign hb.RSP_VALID = rsp_valid_q;
    assign hb.RSP_RDATA = rsp_rdata_q;
    assign hb.RSP_ERR   = rsp_err_q;
    assign hb.ICEIFA    = iceifa_q;
    assign hb.ICEDI     = icedi_q;
    assign hb.ICEWR     = icewr_q;
    assign hb.BUSY      = busy_q;

endmodule
